// File: rtl/i2c_write.sv
// I2C bit/byte transmitter: shifts one bit or one byte MSB-first onto SDA in step
// with external SCL, honouring the data hold time and flagging arbitration loss / bus errors.
module i2c_write #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       is_byte,
  input  logic [7:0] data_i,
  output logic       sda_o,
  output logic       busy,
  output logic       wr_finish,
  output logic       arb_lost,
  output logic       bus_err,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HOLD  = 3'd1;
  localparam logic [2:0] DRIVE = 3'd2;
  localparam logic [2:0] TAIL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] hold_cnt;
  logic       byte_mode;
  logic       scl_last;
  logic       sda_last;

  logic scl_fall;
  logic arb_hit;
  logic err_hit;
  logic last_bit;

  assign scl_fall = scl_last & ~scl_i;
  assign arb_hit  = scl_i & sda_o & ~sda_i;
  assign err_hit  = scl_i & scl_last & (sda_i ^ sda_last);
  assign last_bit = ~byte_mode | (bit_cnt == 3'd7);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sda_o     <= 1'b1;
      wr_finish <= 1'b0;
      arb_lost  <= 1'b0;
      bus_err   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      byte_mode <= 1'b0;
      scl_last  <= 1'b1;
      sda_last  <= 1'b1;
    end else begin
      scl_last  <= scl_i;
      sda_last  <= sda_i;
      wr_finish <= 1'b0;
      arb_lost  <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          sda_o <= 1'b1;
          if (wr_en) begin
            shreg     <= is_byte ? data_i : {data_i[0], 7'b0};
            byte_mode <= is_byte;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 4'd1;
          if (!wr_en) begin
            sda_o <= 1'b1;
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            sda_o <= shreg[7];
            state <= DRIVE;
          end
        end
        DRIVE: begin
          // Abort wins over status; arbitration and bus error may pulse together.
          if (!wr_en) begin
            sda_o <= 1'b1;
            state <= IDLE;
          end else if (arb_hit || err_hit) begin
            arb_lost <= arb_hit;
            bus_err  <= err_hit;
            sda_o    <= 1'b1;
            state    <= DONE;
          end else if (scl_fall) begin
            hold_cnt <= '0;
            if (last_bit) begin
              wr_finish <= 1'b1;
              state     <= TAIL;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              state   <= HOLD;
            end
          end
        end
        TAIL: begin
          hold_cnt <= hold_cnt + 4'd1;
          if (hold_cnt == HOLD_LAST) begin
            sda_o <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          sda_o <= 1'b1;
          if (!wr_en) state <= IDLE;
        end
        default: begin
          sda_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write.sv
// Directed bench for i2c_write: three instances (HOLD_CYCLES 2, 1, 15) share stimulus.
module tb_i2c_write;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       is_byte;
  logic [7:0] data_i;
  logic       scl;
  logic       peer;
  logic       force_en;
  logic       force_val;
  logic [2:0] so_a, by_a, wf_a, al_a, be_a, si_a;

  int checks = 0;
  int failures = 0;
  int hv[3] = '{2, 1, 15};

  assign si_a[0] = force_en ? force_val : (so_a[0] & peer);
  assign si_a[1] = so_a[1];
  assign si_a[2] = so_a[2];

  i2c_write #(.HOLD_CYCLES(2)) u_h2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .is_byte(is_byte), .data_i(data_i),
    .sda_o(so_a[0]), .busy(by_a[0]), .wr_finish(wf_a[0]), .arb_lost(al_a[0]),
    .bus_err(be_a[0]), .scl_i(scl), .sda_i(si_a[0])
  );
  i2c_write #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .is_byte(is_byte), .data_i(data_i),
    .sda_o(so_a[1]), .busy(by_a[1]), .wr_finish(wf_a[1]), .arb_lost(al_a[1]),
    .bus_err(be_a[1]), .scl_i(scl), .sda_i(si_a[1])
  );
  i2c_write #(.HOLD_CYCLES(15)) u_h15 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .is_byte(is_byte), .data_i(data_i),
    .sda_o(so_a[2]), .busy(by_a[2]), .wr_finish(wf_a[2]), .arb_lost(al_a[2]),
    .bus_err(be_a[2]), .scl_i(scl), .sda_i(si_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full transfer with SCL half-period L; checks SDA timing of every DUT in mask.
  task automatic xfer(input logic [7:0] d, input logic byt, input int L,
                      input logic [2:0] mask, input string tag);
    logic [7:0] sr;
    logic       prev;
    int         nbits;
    nbits = byt ? 8 : 1;
    sr    = byt ? d : {d[0], 7'b0};
    prev  = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < L; c++) begin
        @(negedge clk);
        if (c == 0) begin
          scl = 1'b0;
          if (b == 0) begin
            wr_en = 1'b1; is_byte = byt; data_i = d;
          end
        end else if (b == 0 && c == 1) begin
          data_i = ~d;
        end
        for (int k = 0; k < 3; k++) begin
          if (mask[k]) begin
            if (c == hv[k])
              chk($sformatf("%s_h%0d_b%0d_old", tag, hv[k], b), so_a[k], prev);
            if (c == hv[k] + 1) begin
              chk($sformatf("%s_h%0d_b%0d_new", tag, hv[k], b), so_a[k], sr[7]);
              chk($sformatf("%s_h%0d_b%0d_nofin", tag, hv[k], b), wf_a[k], 1'b0);
              chk($sformatf("%s_h%0d_b%0d_busy", tag, hv[k], b), by_a[k], 1'b1);
            end
          end
        end
      end
      for (int c = 0; c < L; c++) begin
        @(negedge clk);
        if (c == 0) scl = 1'b1;
      end
      prev = sr[7];
      sr   = {sr[6:0], 1'b0};
    end
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      if (c == 0) scl = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (mask[k]) begin
          if (c == 1) chk($sformatf("%s_h%0d_fin1", tag, hv[k]), wf_a[k], 1'b1);
          if (c == 2) chk($sformatf("%s_h%0d_fin0", tag, hv[k]), wf_a[k], 1'b0);
          if (c == hv[k]) chk($sformatf("%s_h%0d_tail_old", tag, hv[k]), so_a[k], prev);
          if (c == hv[k] + 1) begin
            chk($sformatf("%s_h%0d_release", tag, hv[k]), so_a[k], 1'b1);
            chk($sformatf("%s_h%0d_done_busy", tag, hv[k]), by_a[k], 1'b1);
          end
        end
      end
    end
  endtask

  task automatic end_xfer(input logic [2:0] mask, input string tag);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      if (mask[k]) chk($sformatf("%s_h%0d_busy_held", tag, hv[k]), by_a[k], 1'b1);
    scl = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        chk($sformatf("%s_h%0d_idle_busy", tag, hv[k]), by_a[k], 1'b0);
        chk($sformatf("%s_h%0d_idle_sda", tag, hv[k]), so_a[k], 1'b1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; is_byte = 1'b0; data_i = '0;
    scl = 1'b1; peer = 1'b1; force_en = 1'b0; force_val = 1'b1;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_sda_h%0d", hv[k]), so_a[k], 1'b1);
      chk($sformatf("rst_busy_h%0d", hv[k]), by_a[k], 1'b0);
      chk($sformatf("rst_fin_h%0d", hv[k]), wf_a[k], 1'b0);
      chk($sformatf("rst_arb_h%0d", hv[k]), al_a[k], 1'b0);
      chk($sformatf("rst_berr_h%0d", hv[k]), be_a[k], 1'b0);
    end
    rst = 1'b0;
    cyc(2);

    xfer(8'hA5, 1'b1, 10, 3'b011, "byteA5");
    end_xfer(3'b011, "byteA5");
    xfer(8'h00, 1'b0, 10, 3'b011, "ack00");
    end_xfer(3'b011, "ack00");
    xfer(8'hFE, 1'b0, 10, 3'b011, "bitFE");
    end_xfer(3'b011, "bitFE");

    // Arbitration loss on the first (released) bit of 0x80
    @(negedge clk); scl = 1'b0; wr_en = 1'b1; is_byte = 1'b1; data_i = 8'h80;
    cyc(3);
    chk("arb_bit0_sda", so_a[0], 1'b1);
    cyc(6);
    @(negedge clk); scl = 1'b1; peer = 1'b0;
    @(negedge clk);
    chk("arb_pulse", al_a[0], 1'b1);
    chk("arb_sda", so_a[0], 1'b1);
    chk("arb_nofin", wf_a[0], 1'b0);
    chk("arb_noberr", be_a[0], 1'b0);
    @(negedge clk);
    chk("arb_single", al_a[0], 1'b0);
    chk("arb_busy", by_a[0], 1'b1);
    peer = 1'b1;
    cyc(7);
    @(negedge clk); scl = 1'b0;
    cyc(4);
    chk("arb_done_nofin", wf_a[0], 1'b0);
    chk("arb_done_sda", so_a[0], 1'b1);
    chk("arb_done_busy", by_a[0], 1'b1);
    @(negedge clk); wr_en = 1'b0; scl = 1'b1;
    @(negedge clk);
    chk("arb_idle", by_a[0], 1'b0);

    // STOP-like SDA rise while SCL high and DUT drives 0
    @(negedge clk); scl = 1'b0; wr_en = 1'b1; is_byte = 1'b1; data_i = 8'h00;
    cyc(3);
    chk("berr_sda0", so_a[0], 1'b0);
    cyc(6);
    @(negedge clk); scl = 1'b1;
    cyc(3);
    @(negedge clk); force_en = 1'b1; force_val = 1'b1;
    @(negedge clk);
    chk("berr_pulse", be_a[0], 1'b1);
    chk("berr_sda", so_a[0], 1'b1);
    chk("berr_nofin", wf_a[0], 1'b0);
    chk("berr_noarb", al_a[0], 1'b0);
    @(negedge clk);
    chk("berr_single", be_a[0], 1'b0);
    chk("berr_busy", by_a[0], 1'b1);
    force_en = 1'b0;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    chk("berr_idle", by_a[0], 1'b0);

    // Abort during bit 3 of 0xA5 (bit value 0)
    @(negedge clk); scl = 1'b0; wr_en = 1'b1; is_byte = 1'b1; data_i = 8'hA5;
    cyc(9);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); scl = 1'b1;
      cyc(9);
      @(negedge clk); scl = 1'b0;
      if (b < 2) cyc(9);
    end
    cyc(2);
    chk("abort_b3_old", so_a[0], 1'b1);
    cyc(1);
    chk("abort_b3_sda", so_a[0], 1'b0);
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    chk("abort_sda", so_a[0], 1'b1);
    chk("abort_busy", by_a[0], 1'b0);
    chk("abort_nofin", wf_a[0], 1'b0);
    scl = 1'b1;
    cyc(2);

    // Reset mid-byte, then a clean 0x3C transfer
    @(negedge clk); scl = 1'b0; wr_en = 1'b1; is_byte = 1'b1; data_i = 8'h00;
    cyc(4);
    chk("midrst_sda0", so_a[0], 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_sda", so_a[0], 1'b1);
    chk("midrst_busy", by_a[0], 1'b0);
    chk("midrst_fin", wf_a[0], 1'b0);
    chk("midrst_arb", al_a[0], 1'b0);
    chk("midrst_berr", be_a[0], 1'b0);
    rst = 1'b0; wr_en = 1'b0; scl = 1'b1;
    cyc(2);
    xfer(8'h3C, 1'b1, 10, 3'b001, "after_rst3C");
    end_xfer(3'b001, "after_rst3C");

    // Hold-time sweep on all instances with a slower SCL
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; scl = 1'b1;
    cyc(2);
    xfer(8'h96, 1'b1, 20, 3'b111, "sweep96");
    end_xfer(3'b111, "sweep96");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_write.md
Name: i2c_write

Overview:
- Transmit-side counterpart of the I2C bit/byte reader. Shifts 1 bit or 1 byte (MSB first) onto SDA, in step with an externally generated SCL.
- Serves both master (address/data bytes) and slave (data bytes, ACK bit). Enforces the data hold time after each SCL falling edge.
- Reports master arbitration loss and illegal START/STOP during a transfer.
- Sits beside the reader under the controller FSMs; its SDA output drives the open-drain pad logic.

Parameters:
- HOLD_CYCLES, 2, clk cycles from SCL falling edge (or transfer start) to SDA update; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- wr_en  input  1  transfer enable; asserted by the controller after an SCL falling edge, held for the whole transfer
- is_byte  input  1  1 = send data_i[7:0]; 0 = send data_i[0] only
- data_i  input  8  data to send; sampled only on the transfer start cycle
- sda_o  output  1  0 = pull SDA low, 1 = release
- busy  output  1  transfer in progress
- wr_finish  output  1  one-cycle pulse, last bit completed
- arb_lost  output  1  one-cycle pulse, released SDA read back low while SCL high
- bus_err  output  1  one-cycle pulse, SDA transition while SCL high during a transfer
- scl_i  input  1  SCL, already synchronized externally
- sda_i  input  1  SDA, already synchronized externally

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, sda_o=1, busy=0, wr_finish=0, arb_lost=0, bus_err=0, shift register and counters 0, scl_last=1, sda_last=1.
- scl_last and sda_last are registered copies of scl_i and sda_i.
- scl_fall = scl_last & ~scl_i.
- FSM states: IDLE, HOLD, DRIVE, TAIL, DONE. busy=1 in every state except IDLE.
- IDLE: sda_o=1. When wr_en=1:
  - shreg <= data_i if is_byte, else {data_i[0],7'b0}.
  - bit_cnt <= 0, hold_cnt <= 0, go to HOLD.
- HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1: sda_o <= shreg[7], go to DRIVE. sda_o therefore changes exactly HOLD_CYCLES cycles after entering HOLD.
- DRIVE: sda_o held stable.
  - On scl_fall with bits remaining (is_byte and bit_cnt<7): shreg shifts left by 1, bit_cnt+1, hold_cnt <= 0, go to HOLD.
  - On scl_fall at the last bit (bit_cnt==7 for byte, any bit_cnt for bit mode): wr_finish=1 the next cycle only, hold_cnt <= 0, go to TAIL.
- TAIL: hold_cnt counts as in HOLD, then sda_o <= 1 and go to DONE. Releasing after the hold time lets the peer drive the ACK bit or the next bit.
- DONE: sda_o=1. Go to IDLE when wr_en=0. A new transfer always needs wr_en to be deasserted first.
- Arbitration (DRIVE only): on the cycle where scl_i=1, sda_o=1 and sda_i=0:
  - arb_lost=1 the next cycle, one pulse only.
  - sda_o stays 1; go to DONE; wr_finish is not asserted.
- Bus error (DRIVE only): scl_i=1, scl_last=1 and sda_i!=sda_last gives bus_err=1 the next cycle, one pulse, go to DONE with sda_o=1.
- If the arbitration and bus-error conditions occur in the same cycle, both pulses assert in the same cycle.
- Abort: wr_en=0 in HOLD or DRIVE gives IDLE with sda_o=1 on the next cycle; no status pulse. wr_en=0 in TAIL is ignored until TAIL completes (hold time preserved).
- Reset mid-transfer: all outputs return to reset values on the next edge, independent of state.
- A scl_fall occurring in HOLD (SCL too fast) is ignored. The bit is still sent and waits for the next scl_fall.
- Width rules: bit_cnt is 3 bits with no wrap (a transfer ends at 7). hold_cnt is 4 bits.

Test Plan:
- Byte send: wr_en=1, is_byte=1, data_i=8'hA5, SCL period 20 clk, HOLD_CYCLES=2 -> sda_o follows 1,0,1,0,0,1,0,1; each change lands 2 clk after the SCL fall; wr_finish is a single pulse 1 clk after the 8th fall; sda_o=1 two cycles later; busy stays 1 until wr_en=0.
- Bit send (ACK): is_byte=0, data_i=8'h00 -> sda_o=0 from 2 clk after start; wr_finish 1 clk after the next SCL fall; sda_o=1 2 clk after that.
- Arbitration: send 8'h80; on bit 1 (sda_o=1) force sda_i=0 while SCL high -> arb_lost pulse 1 clk later, no wr_finish, sda_o stays 1, state DONE until wr_en=0.
- Bus error: during DRIVE with SCL high and sda_o=0, make sda_i rise (STOP) -> bus_err pulse 1 clk later, sda_o=1, no wr_finish.
- Abort/reset: drop wr_en during bit 3 -> sda_o=1 the next clk, busy=0. Separately, assert rst mid-byte -> all outputs at reset values the next clk, and a fresh transfer of 8'h3C completes correctly.
- Parameter sweep: HOLD_CYCLES=1 and 15 -> SDA update delay after each SCL fall equals exactly 1 and 15 clk respectively.
